vec_driver: RTL



---
 rtl/vec_driver_pkg.sv | 20 ++
 rtl/vec_driver_fifo.sv | 54 +++++
 rtl/vec_driver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vec_driver_pkg.sv
// vec_driver_pkg: shared types and constants for the vector replay/check stage.
package vec_driver_pkg;

    localparam int CNT_W   = 16;
    localparam int VEC_A_W = 2;
    localparam int VEC_B_W = 2;
    localparam int VEC_R_W = 3;

    typedef struct packed {
        logic [VEC_A_W-1:0] a;
        logic [VEC_B_W-1:0] b;
        logic [VEC_R_W-1:0] exp;
    } vec_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/vec_driver_fifo.sv
// vec_fifo: small synchronous FIFO with a combinational read port; the
// extra pointer bit distinguishes full from empty.
module vec_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_one
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_one     = ((r_wr_ptr - r_rd_ptr) == PTR_ONE);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/vec_driver.sv
// vec_driver: replays buffered {a, b, expected} vectors onto a DUT at one per
// cycle and scores the DUT result a fixed number of cycles later.
module vec_driver
    import vec_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int A_W   = VEC_A_W,
    parameter int B_W   = VEC_B_W,
    parameter int R_W   = VEC_R_W,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [A_W-1:0]   push_a,
    input  logic [B_W-1:0]   push_b,
    input  logic [R_W-1:0]   push_exp,
    input  logic             start,
    output logic [A_W-1:0]   dut_a,
    output logic [B_W-1:0]   dut_b,
    output logic             dut_valid,
    input  logic [R_W-1:0]   dut_res,
    output logic             err_pulse,
    output logic [R_W-1:0]   err_got,
    output logic [R_W-1:0]   err_exp,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy,
    output logic             done
);
    localparam int VW = A_W + B_W + R_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [VW-1:0]    w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_one;
    logic             w_push;
    logic             w_issue;
    logic             w_pipe_busy;
    logic             w_cmp_valid;
    logic             w_cmp_ok;
    logic [A_W-1:0]   w_rd_a;
    logic [B_W-1:0]   w_rd_b;
    logic [R_W-1:0]   w_rd_exp;

    logic [A_W-1:0]   r_dut_a;
    logic [B_W-1:0]   r_dut_b;
    logic [LAT:0]     r_pv;
    logic [R_W-1:0]   r_pe [0:LAT];
    logic             r_err_pulse;
    logic [R_W-1:0]   r_err_got;
    logic [R_W-1:0]   r_err_exp;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    assign w_push     = push_valid && !w_fifo_full;
    assign w_issue    = (r_state == S_RUN) && !w_fifo_empty;
    assign w_rd_a     = w_fifo_rdata[VW-1 -: A_W];
    assign w_rd_b     = w_fifo_rdata[R_W +: B_W];
    assign w_rd_exp   = w_fifo_rdata[R_W-1:0];

    vec_fifo #(
        .W     (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({push_a, push_b, push_exp}),
        .i_pop   (w_issue),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_one   (w_fifo_one)
    );

    // The compare stage itself may still be busy when leaving DRAIN, so done lands right after it.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            w_pipe_busy = w_pipe_busy | r_pv[k];
        end
    end

    // RUN hands over to DRAIN as the last entry issues, unless a push refills the FIFO.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_fifo_empty || (w_fifo_one && !w_push)) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (!w_fifo_empty) begin
                    w_state_next = S_RUN;
                end else if (!w_pipe_busy) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stage 0 of the check pipeline travels with the issued operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dut_a <= '0;
            r_dut_b <= '0;
            r_pv    <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_pe[k] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            if (w_issue) begin
                r_dut_a <= w_rd_a;
                r_dut_b <= w_rd_b;
                r_pe[0] <= w_rd_exp;
            end
            for (int k = 1; k <= LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pe[k] <= r_pe[k-1];
            end
        end
    end

    assign w_cmp_valid = r_pv[LAT];
    assign w_cmp_ok    = (dut_res == r_pe[LAT]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_pulse <= 1'b0;
            r_err_got   <= '0;
            r_err_exp   <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_err_pulse <= w_cmp_valid && !w_cmp_ok;
            if (w_cmp_valid) begin
                if (w_cmp_ok) begin
                    if (r_pass_cnt != CNT_MAX) begin
                        r_pass_cnt <= r_pass_cnt + CNT_ONE;
                    end
                end else begin
                    if (r_fail_cnt != CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + CNT_ONE;
                    end
                    r_err_got <= dut_res;
                    r_err_exp <= r_pe[LAT];
                end
            end
        end
    end

    assign push_ready = !w_fifo_full;
    assign dut_a      = r_dut_a;
    assign dut_b      = r_dut_b;
    assign dut_valid  = r_pv[0];
    assign err_pulse  = r_err_pulse;
    assign err_got    = r_err_got;
    assign err_exp    = r_err_exp;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule
